// File: rtl/cheri_scrub_regfile.sv
// Flip-flop CHERI capability register file: per-word valid bits, multi-port write,
// masked group fast-clear and a multi-cycle scrub engine that zeroes stale storage.
`timescale 1ns/10ps
module cheri_scrub_regfile #(
  parameter int DATA_WIDTH     = 129,
  parameter int NUM_WORDS      = 32,
  parameter int NR_READ_PORTS  = 2,
  parameter int NR_WRITE_PORTS = 2,
  parameter int CLR_LANES      = 4,
  parameter int ZERO_REG_ZERO  = 1,
  localparam int AW = $clog2(NUM_WORDS),
  localparam int GW = (NUM_WORDS > 8) ? $clog2(NUM_WORDS / 8) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NR_READ_PORTS*AW-1:0]            raddr_i,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0]    rdata_o,
  input  logic [NR_WRITE_PORTS*AW-1:0]           waddr_i,
  input  logic [NR_WRITE_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]              we_i,
  input  logic                                   clr_valid_i,
  output logic                                   clr_ready_o,
  input  logic [GW-1:0]                          clr_group_i,
  input  logic [7:0]                             clr_mask_i,
  input  logic                                   scrub_req_i,
  output logic                                   busy_o,
  output logic                                   scrub_done_o
);

  typedef enum logic {IDLE, SCRUB} state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_WORDS - CLR_LANES);
  localparam logic [AW-1:0] IDX_STEP = AW'(CLR_LANES);

  state_e          state_reg, state_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic            done_reg, done_next;
  logic            scrub_start;

  logic [DATA_WIDTH-1:0] mem_reg [NUM_WORDS];
  logic [NUM_WORDS-1:0]  v_reg;

  logic [NUM_WORDS-1:0]  wr_en;
  logic [DATA_WIDTH-1:0] wr_data [NUM_WORDS];
  logic [NUM_WORDS-1:0]  scrub_zero;
  logic [NUM_WORDS-1:0]  clr_hit;
  logic                  clr_fire;
  logic                  scrubbing;

  assign scrubbing    = (state_reg == SCRUB);
  assign busy_o       = scrubbing;
  assign clr_ready_o  = (state_reg == IDLE);
  assign scrub_done_o = done_reg;
  assign clr_fire     = clr_valid_i && clr_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    done_next   = 1'b0;
    scrub_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (scrub_req_i) begin
          state_next  = SCRUB;
          idx_next    = '0;
          scrub_start = 1'b1;
        end
      end
      SCRUB: begin
        idx_next = idx_reg + IDX_STEP;
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
          idx_next   = '0;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Ports are scanned in ascending order so the highest-indexed port wins on a collision.
  always_comb begin
    for (int w = 0; w < NUM_WORDS; w++) begin
      wr_en[w]   = 1'b0;
      wr_data[w] = '0;
    end
    for (int j = 0; j < NR_WRITE_PORTS; j++) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (we_i[j] && (waddr_i[j*AW +: AW] == w[AW-1:0])) begin
          wr_en[w]   = 1'b1;
          wr_data[w] = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      localparam logic [AW-1:0] BASE = AW'((gi / CLR_LANES) * CLR_LANES);
      // Scrub zeroing keys off the valid bit before this edge's writes land.
      assign scrub_zero[gi] = scrubbing && (idx_reg == BASE) && !v_reg[gi];
      assign clr_hit[gi]    = clr_fire && (clr_group_i == GW'(gi / 8)) && clr_mask_i[gi % 8];
    end

    for (gi = 0; gi < NR_READ_PORTS; gi++) begin : g_read
      logic [AW-1:0] ra;
      assign ra = raddr_i[gi*AW +: AW];
      assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = v_reg[ra] ? mem_reg[ra] : '0;
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        mem_reg[w] <= '0;
      end
      v_reg <= '0;
    end else begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if ((ZERO_REG_ZERO != 0) && (w == 0)) begin
          mem_reg[w] <= '0;
          v_reg[w]   <= 1'b0;
        end else if (wr_en[w]) begin
          mem_reg[w] <= wr_data[w];
          v_reg[w]   <= 1'b1;
        end else begin
          if (scrub_zero[w]) begin
            mem_reg[w] <= '0;
          end
          if (scrub_start || clr_hit[w]) begin
            v_reg[w] <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cheri_scrub_regfile.sv
// Randomised and directed bench for cheri_scrub_regfile against a cycle-level
// behavioural model of the valid/data arrays and the scrub schedule.
`timescale 1ns/10ps
module tb_cheri_scrub_regfile;
  localparam int DW  = 129;
  localparam int N   = 32;
  localparam int RP  = 2;
  localparam int WP  = 2;
  localparam int L   = 4;
  localparam int ZRZ = 1;
  localparam int AW  = 5;
  localparam int GW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [RP*AW-1:0]   raddr = '0;
  logic [RP*DW-1:0]   rdata;
  logic [WP*AW-1:0]   waddr = '0;
  logic [WP*DW-1:0]   wdata = '0;
  logic [WP-1:0]      we = '0;
  logic               clr_valid = 1'b0;
  logic               clr_ready;
  logic [GW-1:0]      clr_group = '0;
  logic [7:0]         clr_mask = '0;
  logic               scrub_req = 1'b0;
  logic               busy;
  logic               scrub_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: data, valid, and scrub progress as a cycle count.
  logic [DW-1:0] mem_m [N];
  logic [N-1:0]  v_m;
  bit            scr_m;
  int            k_m;
  bit            done_m;

  cheri_scrub_regfile #(
    .DATA_WIDTH(DW), .NUM_WORDS(N), .NR_READ_PORTS(RP), .NR_WRITE_PORTS(WP),
    .CLR_LANES(L), .ZERO_REG_ZERO(ZRZ)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .raddr_i(raddr), .rdata_o(rdata),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .clr_valid_i(clr_valid), .clr_ready_o(clr_ready), .clr_group_i(clr_group),
    .clr_mask_i(clr_mask), .scrub_req_i(scrub_req), .busy_o(busy),
    .scrub_done_o(scrub_done)
  );

  always #10 clk = ~clk;

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    t[0] = 1'b1;
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] exp_rd(int a);
    return v_m[a] ? mem_m[a] : '0;
  endfunction

  task automatic idle_in();
    we = '0; waddr = '0; wdata = '0;
    clr_valid = 1'b0; clr_group = '0; clr_mask = '0; scrub_req = 1'b0;
  endtask

  task automatic set_wr(int p, int a, logic [DW-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  // Advance one clock; the model sees the inputs as they stand before the edge.
  task automatic tick();
    logic [DW-1:0] mn [N];
    logic [N-1:0]  vn;
    bit sn, dn;
    int kn, a, g;
    mn = mem_m; vn = v_m; sn = scr_m; kn = k_m; dn = 1'b0;
    if (!rst_n) begin
      for (int w = 0; w < N; w++) mn[w] = '0;
      vn = '0; sn = 1'b0; kn = 0;
    end else begin
      if (scr_m) begin
        // The k-th scrub cycle covers words k*L .. k*L+L-1.
        for (int w = 0; w < N; w++)
          if (w / L == k_m && !v_m[w]) mn[w] = '0;
        kn = k_m + 1;
        if (kn == N / L) begin sn = 1'b0; dn = 1'b1; end
      end else begin
        if (clr_valid)
          for (int k = 0; k < 8; k++)
            if (clr_mask[k]) begin
              g = int'(clr_group) * 8 + k;
              if (g < N) vn[g] = 1'b0;
            end
        if (scrub_req) begin vn = '0; sn = 1'b1; kn = 0; end
      end
      for (int p = 0; p < WP; p++)
        if (we[p]) begin
          a = int'(waddr[p*AW +: AW]);
          if (!(ZRZ != 0 && a == 0)) begin
            mn[a] = wdata[p*DW +: DW];
            vn[a] = 1'b1;
          end
        end
    end
    @(posedge clk); #1;
    mem_m = mn; v_m = vn; scr_m = sn; k_m = kn; done_m = dn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    tick(); tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (scrub_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", scrub_done); end
    n_cmp++; if (clr_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", clr_ready); end
    for (int w = 0; w < N; w++) begin
      raddr = {AW'(N - 1 - w), AW'(w)};
      #0.1;
      n_cmp++;
      if (rdata[0 +: DW] !== '0) begin n_bad++; $display("FAIL reset_read r%0d: got %h want 0", w, rdata[0 +: DW]); end
    end
  endtask

  task automatic test_write_read();
    logic [DW-1:0] a5;
    a5 = DW'(8'hA5);
    set_wr(0, 5, a5);
    tick();
    idle_in();
    raddr = {AW'(6), AW'(5)};
    #0.1;
    n_cmp++; if (rdata[0 +: DW] !== a5) begin n_bad++; $display("FAIL wr_r5: got %h want %h", rdata[0 +: DW], a5); end
    n_cmp++; if (rdata[DW +: DW] !== '0) begin n_bad++; $display("FAIL wr_r6: got %h want 0", rdata[DW +: DW]); end
  endtask

  task automatic test_port_priority();
    set_wr(0, 7, DW'(1));
    set_wr(1, 7, DW'(2));
    tick();
    idle_in();
    raddr = {AW'(7), AW'(7)};
    #0.1;
    n_cmp++; if (rdata[0 +: DW] !== DW'(2)) begin n_bad++; $display("FAIL prio_r7: got %h want 2", rdata[0 +: DW]); end
  endtask

  task automatic test_group_clear();
    logic [DW-1:0] want;
    for (int i = 0; i < 8; i += 2) begin
      set_wr(0, 8 + i, DW'(16 + i));
      set_wr(1, 9 + i, DW'(17 + i));
      tick();
    end
    idle_in();
    clr_valid = 1'b1; clr_group = 2'd1; clr_mask = 8'h0F;
    tick();
    idle_in();
    for (int i = 0; i < 8; i++) begin
      raddr = {AW'(0), AW'(8 + i)};
      #0.1;
      want = (i < 4) ? '0 : DW'(16 + i);
      n_cmp++; if (rdata[0 +: DW] !== want) begin n_bad++; $display("FAIL gclr_r%0d: got %h want %h", 8 + i, rdata[0 +: DW], want); end
    end
    set_wr(0, 9, DW'(8'h99));
    tick();
    idle_in();
    raddr = {AW'(0), AW'(9)};
    #0.1;
    n_cmp++; if (rdata[0 +: DW] !== DW'(8'h99)) begin n_bad++; $display("FAIL gclr_rewrite_r9: got %h want 99", rdata[0 +: DW]); end
  endtask

  task automatic test_scrub();
    int busy_cnt, done_cnt;
    logic [DW-1:0] want;
    for (int a = 1; a < N; a += 2) begin
      set_wr(0, a, rand_word());
      if (a + 1 < N) set_wr(1, a + 1, rand_word());
      tick();
      idle_in();
    end
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      n_cmp++; if (busy !== scr_m) begin n_bad++; $display("FAIL scrub_busy c%0d: got %b want %b", c, busy, scr_m); end
      n_cmp++; if (scrub_done !== done_m) begin n_bad++; $display("FAIL scrub_done c%0d: got %b want %b", c, scrub_done, done_m); end
      if (busy === 1'b1) busy_cnt++;
      if (scrub_done === 1'b1) done_cnt++;
      if (c == 0) begin
        for (int w = 0; w < N; w++) begin
          raddr = {AW'(0), AW'(w)};
          #0.1;
          n_cmp++; if (rdata[0 +: DW] !== '0) begin n_bad++; $display("FAIL scrub_read0 r%0d: got %h want 0", w, rdata[0 +: DW]); end
        end
      end
      idle_in();
      if (c == 1) set_wr(0, 20, DW'(8'h55));
      tick();
    end
    idle_in();
    n_cmp++; if (busy_cnt != N / L) begin n_bad++; $display("FAIL scrub_busy_len: got %0d want %0d", busy_cnt, N / L); end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL scrub_done_cnt: got %0d want 1", done_cnt); end
    for (int w = 0; w < N; w++) begin
      want = (w == 20) ? DW'(8'h55) : '0;
      n_cmp++; if (dut.mem_reg[w] !== want) begin n_bad++; $display("FAIL scrub_mem r%0d: got %h want %h", w, dut.mem_reg[w], want); end
      raddr = {AW'(0), AW'(w)};
      #0.1;
      n_cmp++; if (rdata[0 +: DW] !== want) begin n_bad++; $display("FAIL scrub_read r%0d: got %h want %h", w, rdata[0 +: DW], want); end
    end
  endtask

  task automatic test_clear_during_scrub();
    scrub_req = 1'b1;
    tick();
    idle_in();
    set_wr(0, 8, rand_word()); set_wr(1, 9, rand_word());
    tick();
    idle_in();
    set_wr(0, 10, rand_word()); set_wr(1, 11, rand_word());
    tick();
    idle_in();
    clr_valid = 1'b1; clr_group = 2'd1; clr_mask = 8'hFF;
    #0.1;
    n_cmp++; if (clr_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready: got %b want 0", clr_ready); end
    tick();
    idle_in();
    for (int a = 8; a < 12; a++) begin
      raddr = {AW'(0), AW'(a)};
      #0.1;
      n_cmp++; if (rdata[0 +: DW] !== exp_rd(a) || rdata[0 +: DW] === '0) begin
        n_bad++; $display("FAIL busy_clr_ignored r%0d: got %h want %h", a, rdata[0 +: DW], exp_rd(a));
      end
    end
    for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL scrub_timeout: got busy %b want 0", busy); end
    tick();
    set_wr(0, 3, rand_word());
    tick();
    idle_in();
    clr_valid = 1'b1; clr_group = 2'd0; clr_mask = 8'h08; scrub_req = 1'b1;
    tick();
    idle_in();
    raddr = {AW'(0), AW'(3)};
    #0.1;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL clr_scrub_busy: got %b want 1", busy); end
    n_cmp++; if (clr_ready !== 1'b0) begin n_bad++; $display("FAIL clr_scrub_ready: got %b want 0", clr_ready); end
    n_cmp++; if (rdata[0 +: DW] !== '0) begin n_bad++; $display("FAIL clr_scrub_r3: got %h want 0", rdata[0 +: DW]); end
    for (int i = 0; i < 20 && (busy === 1'b1 || scrub_done === 1'b1); i++) tick();
  endtask

  task automatic test_reset_mid_scrub();
    int done_cnt;
    set_wr(0, 2, rand_word()); set_wr(1, 3, rand_word());
    tick();
    idle_in();
    scrub_req = 1'b1;
    tick();
    scrub_req = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    tick();
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (scrub_done === 1'b1) done_cnt++;
      tick();
    end
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL rst_mid_done: got %0d pulses want 0", done_cnt); end
    for (int w = 0; w < N; w++) begin
      raddr = {AW'(0), AW'(w)};
      #0.1;
      n_cmp++; if (rdata[0 +: DW] !== '0) begin n_bad++; $display("FAIL rst_mid_read r%0d: got %h want 0", w, rdata[0 +: DW]); end
    end
  endtask

  task automatic test_zero_reg();
    set_wr(1, 0, DW'(8'hFF));
    tick();
    idle_in();
    raddr = {AW'(0), AW'(0)};
    #0.1;
    n_cmp++; if (rdata[DW +: DW] !== '0) begin n_bad++; $display("FAIL zero_reg_read: got %h want 0", rdata[DW +: DW]); end
    n_cmp++; if (dut.mem_reg[0] !== '0) begin n_bad++; $display("FAIL zero_reg_mem: got %h want 0", dut.mem_reg[0]); end
  endtask

  task automatic test_random();
    int a0, a1;
    for (int c = 0; c < 400; c++) begin
      idle_in();
      for (int p = 0; p < WP; p++)
        if ($urandom_range(1, 0) == 1) set_wr(p, int'($urandom_range(N - 1, 0)), rand_word());
      if ($urandom_range(3, 0) == 0) begin
        clr_valid = 1'b1;
        clr_group = GW'($urandom_range(3, 0));
        clr_mask  = 8'($urandom);
      end
      scrub_req = ($urandom_range(24, 0) == 0);
      tick();
      idle_in();
      a0 = int'($urandom_range(N - 1, 0));
      a1 = int'($urandom_range(N - 1, 0));
      raddr = {AW'(a1), AW'(a0)};
      #0.1;
      n_cmp++; if (rdata[0 +: DW] !== exp_rd(a0)) begin n_bad++; $display("FAIL rand_rd0 c%0d r%0d: got %h want %h", c, a0, rdata[0 +: DW], exp_rd(a0)); end
      n_cmp++; if (rdata[DW +: DW] !== exp_rd(a1)) begin n_bad++; $display("FAIL rand_rd1 c%0d r%0d: got %h want %h", c, a1, rdata[DW +: DW], exp_rd(a1)); end
      n_cmp++; if (busy !== scr_m) begin n_bad++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, scr_m); end
      n_cmp++; if (clr_ready !== !scr_m) begin n_bad++; $display("FAIL rand_ready c%0d: got %b want %b", c, clr_ready, !scr_m); end
      n_cmp++; if (scrub_done !== done_m) begin n_bad++; $display("FAIL rand_done c%0d: got %b want %b", c, scrub_done, done_m); end
    end
    idle_in();
  endtask

  initial begin
    for (int w = 0; w < N; w++) mem_m[w] = '0;
    v_m = '0; scr_m = 1'b0; k_m = 0; done_m = 1'b0;
    test_reset();
    test_write_read();
    test_port_priority();
    test_group_clear();
    test_scrub();
    test_clear_during_scrub();
    test_reset_mid_scrub();
    test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
